// File: rtl/coherence_pkg.sv
// Shared coherence definitions: MOESI encodings, snoop request codes and
// the snoop responder's FSM states.
package coherence_pkg;

    localparam logic [2:0] MOESI_M = 3'b000;
    localparam logic [2:0] MOESI_O = 3'b001;
    localparam logic [2:0] MOESI_E = 3'b010;
    localparam logic [2:0] MOESI_S = 3'b011;
    localparam logic [2:0] MOESI_I = 3'b100;

    localparam logic [3:0] SNP_RD    = 4'b0001;
    localparam logic [3:0] SNP_RDINV = 4'b0111;
    localparam logic [3:0] SNP_INV   = 4'b1101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_UPDATE,
        ST_FILL,
        ST_SEND,
        ST_RESP
    } snoop_fsm_t;

    function automatic logic is_known_snoop(input logic [3:0] code);
        return (code == SNP_RD) || (code == SNP_RDINV) || (code == SNP_INV);
    endfunction

endpackage

// File: rtl/snoop_line_buffer.sv
// One cache line of outgoing snoop data: word-addressed writes while filling,
// sequential beat reads while sending.
module snoop_line_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          ptr_clr,
    input  logic                          ptr_inc,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_last
);

    localparam int WORD_BITS = $clog2(LINE_WORDS);

    logic [DATA_WIDTH-1:0] words [LINE_WORDS];
    logic [WORD_BITS-1:0]  ptr;

    // NOTE: the line is small and must read as zero after reset, so the array
    // is reset like any other flop rather than left for a RAM macro.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                words[i] <= '0;
            end
            ptr <= '0;
        end else begin
            if (wr_en) begin
                words[wr_word] <= wr_data;
            end
            if (ptr_clr) begin
                ptr <= '0;
            end else if (ptr_inc) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    assign rd_data = words[ptr];
    assign rd_last = (ptr == WORD_BITS'(LINE_WORDS - 1));

endmodule

// File: rtl/snoop_responder.sv
// Services peer snoops for one L1: tag lookup, MOESI state update through the
// controller's bus port, and line supply when this cache owns the data.
module snoop_responder
    import coherence_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64,
    parameter int WAYS       = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          snoop_valid,
    output logic                          snoop_ready,
    input  logic [ADDR_WIDTH-1:0]         snoop_addr,
    input  logic [3:0]                    snoop_type,
    input  logic                          cpu_lock,
    output logic                          tag_rd_en,
    output logic [$clog2(SETS)-1:0]       tag_rd_index,
    output logic [ADDR_WIDTH-$clog2(LINE_WORDS*DATA_WIDTH/8)-$clog2(SETS)-1:0] tag_rd_tag,
    input  logic                          tag_hit,
    input  logic [$clog2(WAYS)-1:0]       tag_way,
    input  logic [2:0]                    tag_state,
    output logic                          hit2,
    output logic [2:0]                    hit_way_state2,
    output logic [3:0]                    bus_snoop,
    input  logic [2:0]                    next_state2,
    output logic                          st_wr_en,
    output logic [$clog2(SETS)-1:0]       st_wr_index,
    output logic [$clog2(WAYS)-1:0]       st_wr_way,
    output logic [2:0]                    st_wr_state,
    output logic                          data_rd_en,
    output logic [$clog2(SETS)-1:0]       data_rd_index,
    output logic [$clog2(WAYS)-1:0]       data_rd_way,
    output logic [$clog2(LINE_WORDS)-1:0] data_rd_word,
    input  logic [DATA_WIDTH-1:0]         data_rd_data,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic                          resp_hit,
    output logic                          resp_has_data,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_last
);

    localparam int INDEX_BITS  = $clog2(SETS);
    localparam int WAY_BITS    = $clog2(WAYS);
    localparam int WORD_BITS   = $clog2(LINE_WORDS);
    localparam int OFFSET_BITS = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
    localparam int CNT_BITS    = WORD_BITS + 1;

    snoop_fsm_t            state, state_next;
    logic                  active;
    logic [INDEX_BITS-1:0] index_q;
    logic [TAG_BITS-1:0]   tag_q;
    logic [3:0]            type_q;
    logic                  hit_q;
    logic [WAY_BITS-1:0]   way_q;
    logic [CNT_BITS-1:0]   fill_cnt;

    logic                  eff_hit;
    logic                  supply;
    logic                  buf_wr_en;
    logic [WORD_BITS-1:0]  buf_wr_word;
    logic                  buf_ptr_clr;
    logic                  buf_ptr_inc;
    logic [DATA_WIDTH-1:0] buf_rd_data;
    logic                  buf_rd_last;
    logic                  unused_offset_bits;

    assign unused_offset_bits = ^snoop_addr[OFFSET_BITS-1:0];

    assign eff_hit = tag_hit && (tag_state != MOESI_I);
    assign supply  = eff_hit && ((type_q == SNP_RD) || (type_q == SNP_RDINV))
                     && (tag_state inside {MOESI_M, MOESI_O, MOESI_E});

    // active keeps snoop_ready low while reset is held and for one cycle after.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= ST_IDLE;
            active   <= 1'b0;
            index_q  <= '0;
            tag_q    <= '0;
            type_q   <= '0;
            hit_q    <= 1'b0;
            way_q    <= '0;
            fill_cnt <= '0;
        end else begin
            state  <= state_next;
            active <= 1'b1;
            if (snoop_valid && snoop_ready) begin
                index_q <= snoop_addr[OFFSET_BITS +: INDEX_BITS];
                tag_q   <= snoop_addr[OFFSET_BITS + INDEX_BITS +: TAG_BITS];
                type_q  <= snoop_type;
            end
            if (state == ST_UPDATE) begin
                hit_q    <= eff_hit;
                way_q    <= tag_way;
                fill_cnt <= '0;
            end else if (state == ST_FILL) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // NOTE: every output is given a default before the case so no path
    // leaves one unassigned and a latch cannot be inferred.
    always_comb begin
        state_next     = state;
        snoop_ready    = 1'b0;
        tag_rd_en      = 1'b0;
        tag_rd_index   = '0;
        tag_rd_tag     = '0;
        hit2           = 1'b0;
        hit_way_state2 = MOESI_I;
        bus_snoop      = 4'b0000;
        st_wr_en       = 1'b0;
        st_wr_index    = '0;
        st_wr_way      = '0;
        st_wr_state    = '0;
        data_rd_en     = 1'b0;
        data_rd_index  = '0;
        data_rd_way    = '0;
        data_rd_word   = '0;
        resp_valid     = 1'b0;
        resp_hit       = 1'b0;
        resp_has_data  = 1'b0;
        resp_data      = '0;
        resp_last      = 1'b0;
        buf_wr_en      = 1'b0;
        buf_wr_word    = '0;
        buf_ptr_clr    = 1'b0;
        buf_ptr_inc    = 1'b0;

        case (state)
            ST_IDLE: begin
                snoop_ready = active && !cpu_lock;
                if (snoop_valid && snoop_ready) begin
                    state_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                tag_rd_en    = 1'b1;
                tag_rd_index = index_q;
                tag_rd_tag   = tag_q;
                state_next   = ST_UPDATE;
            end
            ST_UPDATE: begin
                hit2           = eff_hit;
                hit_way_state2 = eff_hit ? tag_state : MOESI_I;
                bus_snoop      = type_q;
                if (eff_hit && is_known_snoop(type_q) && (next_state2 != tag_state)) begin
                    st_wr_en    = 1'b1;
                    st_wr_index = index_q;
                    st_wr_way   = tag_way;
                    st_wr_state = next_state2;
                end
                state_next = supply ? ST_FILL : ST_RESP;
            end
            ST_FILL: begin
                // Reads are issued at counts 0..N-1; each word lands one count later.
                if (fill_cnt < CNT_BITS'(LINE_WORDS)) begin
                    data_rd_en    = 1'b1;
                    data_rd_index = index_q;
                    data_rd_way   = way_q;
                    data_rd_word  = fill_cnt[WORD_BITS-1:0];
                end
                if (fill_cnt != '0) begin
                    buf_wr_en   = 1'b1;
                    buf_wr_word = WORD_BITS'(fill_cnt - 1'b1);
                end
                if (fill_cnt == CNT_BITS'(LINE_WORDS)) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                resp_valid    = 1'b1;
                resp_hit      = 1'b1;
                resp_has_data = 1'b1;
                resp_data     = buf_rd_data;
                resp_last     = buf_rd_last;
                if (resp_ready) begin
                    if (buf_rd_last) begin
                        buf_ptr_clr = 1'b1;
                        state_next  = ST_IDLE;
                    end else begin
                        buf_ptr_inc = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_hit   = hit_q;
                resp_last  = 1'b1;
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    snoop_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buffer (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .wr_en   (buf_wr_en),
        .wr_word (buf_wr_word),
        .wr_data (data_rd_data),
        .ptr_clr (buf_ptr_clr),
        .ptr_inc (buf_ptr_inc),
        .rd_data (buf_rd_data),
        .rd_last (buf_rd_last)
    );

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder with a small MOESI bus-side model and a
// data array model that answers one cycle after each read strobe.
module tb_snoop_responder;
    import coherence_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          snoop_valid = 1'b0;
    logic          snoop_ready;
    logic [AW-1:0] snoop_addr = '0;
    logic [3:0]    snoop_type = '0;
    logic          cpu_lock = 1'b0;
    logic          tag_rd_en;
    logic [5:0]    tag_rd_index;
    logic [21:0]   tag_rd_tag;
    logic          tag_hit = 1'b0;
    logic [1:0]    tag_way = '0;
    logic [2:0]    tag_state = MOESI_I;
    logic          hit2;
    logic [2:0]    hit_way_state2;
    logic [3:0]    bus_snoop;
    logic [2:0]    next_state2;
    logic          st_wr_en;
    logic [5:0]    st_wr_index;
    logic [1:0]    st_wr_way;
    logic [2:0]    st_wr_state;
    logic          data_rd_en;
    logic [5:0]    data_rd_index;
    logic [1:0]    data_rd_way;
    logic [1:0]    data_rd_word;
    logic [DW-1:0] data_rd_data = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          resp_hit;
    logic          resp_has_data;
    logic [DW-1:0] resp_data;
    logic          resp_last;

    int checks = 0;
    int failures = 0;
    int st_wr_cnt = 0;
    int data_rd_cnt = 0;

    always #5 ACLK = ~ACLK;

    snoop_responder dut (
        .ACLK           (ACLK),
        .ARESETn        (ARESETn),
        .snoop_valid    (snoop_valid),
        .snoop_ready    (snoop_ready),
        .snoop_addr     (snoop_addr),
        .snoop_type     (snoop_type),
        .cpu_lock       (cpu_lock),
        .tag_rd_en      (tag_rd_en),
        .tag_rd_index   (tag_rd_index),
        .tag_rd_tag     (tag_rd_tag),
        .tag_hit        (tag_hit),
        .tag_way        (tag_way),
        .tag_state      (tag_state),
        .hit2           (hit2),
        .hit_way_state2 (hit_way_state2),
        .bus_snoop      (bus_snoop),
        .next_state2    (next_state2),
        .st_wr_en       (st_wr_en),
        .st_wr_index    (st_wr_index),
        .st_wr_way      (st_wr_way),
        .st_wr_state    (st_wr_state),
        .data_rd_en     (data_rd_en),
        .data_rd_index  (data_rd_index),
        .data_rd_way    (data_rd_way),
        .data_rd_word   (data_rd_word),
        .data_rd_data   (data_rd_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_hit       (resp_hit),
        .resp_has_data  (resp_has_data),
        .resp_data      (resp_data),
        .resp_last      (resp_last)
    );

    function automatic logic [2:0] moesi_next(input logic [2:0] st, input logic [3:0] snp);
        case (snp)
            SNP_RD:             return (st == MOESI_M) ? MOESI_O : (st == MOESI_E) ? MOESI_S : st;
            SNP_RDINV, SNP_INV: return MOESI_I;
            default:            return st;
        endcase
    endfunction

    function automatic logic [DW-1:0] mem_word(input logic [5:0] idx, input logic [1:0] way,
                                               input logic [1:0] w);
        return 32'hC0DE_0000 | (32'(idx) << 8) | (32'(way) << 4) | 32'(w);
    endfunction

    always_comb next_state2 = moesi_next(hit_way_state2, bus_snoop);

    always @(posedge ACLK) begin
        if (data_rd_en) data_rd_data <= mem_word(data_rd_index, data_rd_way, data_rd_word);
        if (st_wr_en) st_wr_cnt <= st_wr_cnt + 1;
        if (data_rd_en) data_rd_cnt <= data_rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [61:0] ctl_outputs();
        return {snoop_ready, tag_rd_en, tag_rd_index, tag_rd_tag, hit2, bus_snoop, st_wr_en,
                st_wr_index, st_wr_way, st_wr_state, data_rd_en, data_rd_index, data_rd_way,
                data_rd_word, resp_valid, resp_hit, resp_has_data, resp_last};
    endfunction

    // Called at a negedge; returns at the negedge of the cycle after the handshake.
    task automatic start_snoop(input logic [AW-1:0] addr, input logic [3:0] typ);
        snoop_valid = 1'b1;
        snoop_addr  = addr;
        snoop_type  = typ;
        for (int n = 0; n < 20 && !snoop_ready; n++) @(negedge ACLK);
        check("snoop_ready", snoop_ready, 1);
        @(posedge ACLK);
        @(negedge ACLK);
        snoop_valid = 1'b0;
    endtask

    task automatic run_snoop(input logic [AW-1:0] addr, input logic [3:0] typ, input logic hit,
                             input logic [1:0] way, input logic [2:0] st, input logic exp_wr,
                             input logic [2:0] exp_state, input logic exp_supply,
                             input logic exp_rhit, input logic toggle);
        logic [5:0]  idx;
        logic [21:0] tg;
        int          wr0, rd0, beat;
        logic        phase;
        idx = addr[9:4];
        tg  = addr[31:10];
        tag_hit = hit;
        tag_way = way;
        tag_state = st;
        wr0 = st_wr_cnt;
        rd0 = data_rd_cnt;
        start_snoop(addr, typ);
        check("tag_rd_en", tag_rd_en, 1);
        check("tag_rd_index", tag_rd_index, idx);
        check("tag_rd_tag", tag_rd_tag, tg);
        @(negedge ACLK);
        check("hit2", hit2, hit && (st != MOESI_I));
        check("bus_snoop", bus_snoop, typ);
        check("st_wr_en", st_wr_en, exp_wr);
        if (exp_wr) begin
            check("st_wr_state", st_wr_state, exp_state);
            check("st_wr_way", st_wr_way, way);
            check("st_wr_index", st_wr_index, idx);
        end
        @(negedge ACLK);
        if (exp_supply) begin
            for (int k = 0; k < LW; k++) begin
                check("data_rd_en", data_rd_en, 1);
                check("data_rd_word", data_rd_word, k);
                check("data_rd_loc", {data_rd_index, data_rd_way}, {idx, way});
                check("fill_no_valid", resp_valid, 0);
                @(negedge ACLK);
            end
            check("fill_tail_rd", data_rd_en, 0);
            check("fill_tail_valid", resp_valid, 0);
            @(negedge ACLK);
            beat = 0;
            phase = 1'b0;
            for (int n = 0; n < 40 && beat < LW; n++) begin
                resp_ready = toggle ? phase : 1'b1;
                phase = ~phase;
                check("send_valid", resp_valid, 1);
                check("send_has_data", resp_has_data, 1);
                check("send_hit", resp_hit, 1);
                check("send_data", resp_data, mem_word(idx, way, beat[1:0]));
                check("send_last", resp_last, beat == LW - 1);
                if (resp_ready) beat++;
                @(negedge ACLK);
            end
            check("beats", beat, LW);
        end else begin
            resp_ready = 1'b1;
            check("resp_valid", resp_valid, 1);
            check("resp_has_data", resp_has_data, 0);
            check("resp_last", resp_last, 1);
            check("resp_hit", resp_hit, exp_rhit);
            @(negedge ACLK);
        end
        resp_ready = 1'b0;
        check("ready_return", snoop_ready, 1);
        check("resp_idle", resp_valid, 0);
        check("st_wr_count", st_wr_cnt - wr0, exp_wr);
        check("data_rd_count", data_rd_cnt - rd0, exp_supply ? LW : 0);
    endtask

    initial begin
        #12;
        check("rst_outputs", ctl_outputs(), 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_hws2", hit_way_state2, MOESI_I);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        check("post_rst_ready", snoop_ready, 1);
        check("idle_hws2", hit_way_state2, MOESI_I);

        // addr, type, hit, way, state, wr, wr_state, supply, resp_hit, toggle
        run_snoop(32'h1234_5050, SNP_RD,    1'b1, 2'd2, MOESI_M, 1'b1, MOESI_O, 1'b1, 1'b1, 1'b0);
        run_snoop(32'hABCD_03F0, SNP_RDINV, 1'b1, 2'd1, MOESI_E, 1'b1, MOESI_I, 1'b1, 1'b1, 1'b1);
        run_snoop(32'h0000_0420, SNP_INV,   1'b1, 2'd3, MOESI_S, 1'b1, MOESI_I, 1'b0, 1'b1, 1'b0);
        run_snoop(32'h5555_0120, SNP_RD,    1'b0, 2'd0, MOESI_M, 1'b0, MOESI_I, 1'b0, 1'b0, 1'b0);
        run_snoop(32'h7777_0090, SNP_RD,    1'b1, 2'd0, MOESI_S, 1'b0, MOESI_S, 1'b0, 1'b1, 1'b0);
        run_snoop(32'h2468_0200, 4'b0010,   1'b1, 2'd1, MOESI_M, 1'b0, MOESI_M, 1'b0, 1'b1, 1'b0);
        run_snoop(32'h1357_0310, SNP_INV,   1'b1, 2'd2, MOESI_I, 1'b0, MOESI_I, 1'b0, 1'b0, 1'b0);

        // Lock holds off acceptance; dropping it accepts in the same cycle.
        tag_hit = 1'b0;
        cpu_lock = 1'b1;
        snoop_valid = 1'b1;
        snoop_addr = 32'h0BAD_0070;
        snoop_type = SNP_RD;
        for (int n = 0; n < 3; n++) begin
            @(negedge ACLK);
            check("lock_ready", snoop_ready, 0);
        end
        cpu_lock = 1'b0;
        #1;
        check("unlock_ready", snoop_ready, 1);
        @(posedge ACLK);
        @(negedge ACLK);
        snoop_valid = 1'b0;
        cpu_lock = 1'b1;
        check("lock_lookup", tag_rd_en, 1);
        @(negedge ACLK);
        @(negedge ACLK);
        resp_ready = 1'b1;
        check("lock_resp_valid", resp_valid, 1);
        check("lock_resp_hit", resp_hit, 0);
        @(negedge ACLK);
        resp_ready = 1'b0;
        check("lock_idle_ready", snoop_ready, 0);
        cpu_lock = 1'b0;

        // Reset in the middle of a line fill.
        @(negedge ACLK);
        tag_hit = 1'b1;
        tag_way = 2'd3;
        tag_state = MOESI_M;
        start_snoop(32'hFACE_0560, SNP_RD);
        @(negedge ACLK);
        @(negedge ACLK);
        @(negedge ACLK);
        check("mid_fill_rd", data_rd_en, 1);
        #1;
        ARESETn = 1'b0;
        #1;
        check("mid_rst_outputs", ctl_outputs(), 0);
        check("mid_rst_data", resp_data, 0);
        check("mid_rst_hws2", hit_way_state2, MOESI_I);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        check("rst_recover_ready", snoop_ready, 1);
        run_snoop(32'h3030_0680, SNP_RD,    1'b1, 2'd1, MOESI_O, 1'b0, MOESI_O, 1'b1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
